traffic_light_monitor: RTL and testbench

- Receive-side checker for the red/yellow/green light interface driven by the traffic light controller.
- Decodes the three lamp lines into a phase, measures each phase's duration in clock cycles, and checks legal one-hot encoding, G->Y->R->G order and per-phase timing against nominal ±tolerance.
- Reports a sticky first fault and pulses once per complete, clean cycle.
- Sits beside the controller on the same 50 MHz clock, for lamp-driver safety interlock and bench self-checking.

---
 rtl/traffic_light_pkg.sv | 37 +++
 rtl/traffic_phase_timer.sv | 54 +++++
 rtl/traffic_light_monitor.sv | 139 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared lamp/phase encodings, fault codes and default timing for the
// traffic light controller and its receive-side monitor.
package traffic_light_pkg;

  localparam logic [1:0] S_GREEN   = 2'b00;
  localparam logic [1:0] S_YELLOW  = 2'b01;
  localparam logic [1:0] S_RED     = 2'b10;
  localparam logic [1:0] S_INVALID = 2'b11;

  localparam logic [2:0] FC_NONE          = 3'd0;
  localparam logic [2:0] FC_ILLEGAL_COMBO = 3'd1;
  localparam logic [2:0] FC_BAD_ORDER     = 3'd2;
  localparam logic [2:0] FC_SHORT_PHASE   = 3'd3;
  localparam logic [2:0] FC_LONG_PHASE    = 3'd4;

  localparam int unsigned GREEN_CYCLES_DEF  = 500_000_000;
  localparam int unsigned YELLOW_CYCLES_DEF = 250_000_000;
  localparam int unsigned RED_CYCLES_DEF    = 1_500_000_000;

  typedef enum logic [1:0] {
    MON_ACQUIRE = 2'd0,
    MON_TRACK   = 2'd1,
    MON_FAULT   = 2'd2
  } mon_state_t;

  function automatic logic [1:0] decode_lamps(input logic r, input logic y, input logic g);
    logic [1:0] p;
    case ({r, y, g})
      3'b001:  p = S_GREEN;
      3'b010:  p = S_YELLOW;
      3'b100:  p = S_RED;
      default: p = S_INVALID;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Saturating phase-duration counter with NOM +/- TOL window compare,
// nominal selected by the phase currently being timed.
module traffic_phase_timer
  import traffic_light_pkg::*;
#(
  parameter int unsigned GREEN_CYCLES  = GREEN_CYCLES_DEF,
  parameter int unsigned YELLOW_CYCLES = YELLOW_CYCLES_DEF,
  parameter int unsigned RED_CYCLES    = RED_CYCLES_DEF,
  parameter int unsigned TOL           = 16,
  parameter int unsigned CNT_W         = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       change,
  input  logic [1:0] phase,
  output logic       len_short,
  output logic       len_long,
  output logic       overrun
);

  logic [CNT_W-1:0] dur;
  logic [CNT_W-1:0] dur_next;
  logic [CNT_W-1:0] nom;
  logic [CNT_W-1:0] lo;
  logic [CNT_W-1:0] hi;
  logic [CNT_W-1:0] tol_w;

  assign tol_w = CNT_W'(TOL);

  always_comb begin
    nom = CNT_W'(RED_CYCLES);
    case (phase)
      S_GREEN:  nom = CNT_W'(GREEN_CYCLES);
      S_YELLOW: nom = CNT_W'(YELLOW_CYCLES);
      default:  nom = CNT_W'(RED_CYCLES);
    endcase
  end

  assign lo = (nom > tol_w) ? nom - tol_w : '0;
  assign hi = nom + tol_w;

  assign dur_next = change ? CNT_W'(1) : ((&dur) ? dur : dur + CNT_W'(1));

  // dur holds the completed length during the change cycle, before the reload
  assign len_short = dur < lo;
  assign len_long  = dur > hi;
  assign overrun   = !change && (dur_next > hi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dur <= '0;
    else     dur <= dur_next;
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the red/yellow/green lamp lines: decodes the phase,
// checks encoding, G->Y->R order and per-phase timing, reports first fault.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int unsigned GREEN_CYCLES  = GREEN_CYCLES_DEF,
  parameter int unsigned YELLOW_CYCLES = YELLOW_CYCLES_DEF,
  parameter int unsigned RED_CYCLES    = RED_CYCLES_DEF,
  parameter int unsigned TOL           = 16,
  parameter int unsigned CNT_W         = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        red,
  input  logic        yellow,
  input  logic        green,
  output logic [1:0]  phase,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic        cycle_done,
  output logic [15:0] cycle_count
);

  logic       red_q, yellow_q, green_q;
  logic       lamp_vld;
  logic [1:0] cur;
  logic       change;
  logic       legal;
  logic       len_short, len_long, overrun;

  mon_state_t state, state_d;
  logic [2:0] code_d;
  logic [2:0] chk;
  logic       done_d;
  logic       seen_g, seen_y, seen_g_d, seen_y_d;

  // lamp_vld masks the all-off input register right after reset
  assign cur    = decode_lamps(red_q, yellow_q, green_q);
  assign change = lamp_vld && (cur != phase);
  assign legal  = (phase == S_GREEN  && cur == S_YELLOW) ||
                  (phase == S_YELLOW && cur == S_RED)    ||
                  (phase == S_RED    && cur == S_GREEN);

  traffic_phase_timer #(
    .GREEN_CYCLES  (GREEN_CYCLES),
    .YELLOW_CYCLES (YELLOW_CYCLES),
    .RED_CYCLES    (RED_CYCLES),
    .TOL           (TOL),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .change    (change),
    .phase     (phase),
    .len_short (len_short),
    .len_long  (len_long),
    .overrun   (overrun)
  );

  always_comb begin
    state_d  = state;
    code_d   = fault_code;
    done_d   = 1'b0;
    seen_g_d = seen_g;
    seen_y_d = seen_y;
    chk      = FC_NONE;
    case (state)
      MON_ACQUIRE: begin
        if (lamp_vld && cur == S_INVALID) begin
          state_d = MON_FAULT;
          code_d  = FC_ILLEGAL_COMBO;
        end else if (change && phase != S_INVALID) begin
          if (!legal) begin
            state_d = MON_FAULT;
            code_d  = FC_BAD_ORDER;
          end else begin
            state_d = MON_TRACK;
          end
        end
      end
      MON_TRACK: begin
        if (change) begin
          if (cur == S_INVALID)  chk = FC_ILLEGAL_COMBO;
          else if (!legal)       chk = FC_BAD_ORDER;
          else if (len_short)    chk = FC_SHORT_PHASE;
          else if (len_long)     chk = FC_LONG_PHASE;
          if (chk != FC_NONE) begin
            state_d = MON_FAULT;
            code_d  = chk;
          end else begin
            if (phase == S_GREEN)  seen_g_d = 1'b1;
            if (phase == S_YELLOW) seen_y_d = 1'b1;
            if (phase == S_RED && seen_g && seen_y) begin
              done_d   = 1'b1;
              seen_g_d = 1'b0;
              seen_y_d = 1'b0;
            end
          end
        end else if (overrun) begin
          state_d = MON_FAULT;
          code_d  = FC_LONG_PHASE;
        end
      end
      MON_FAULT: state_d = MON_FAULT;
      default:   state_d = MON_ACQUIRE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_q       <= 1'b0;
      yellow_q    <= 1'b0;
      green_q     <= 1'b0;
      lamp_vld    <= 1'b0;
      phase       <= S_INVALID;
      state       <= MON_ACQUIRE;
      seen_g      <= 1'b0;
      seen_y      <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      cycle_done  <= 1'b0;
      cycle_count <= '0;
    end else begin
      red_q       <= red;
      yellow_q    <= yellow;
      green_q     <= green;
      lamp_vld    <= 1'b1;
      phase       <= cur;
      state       <= state_d;
      seen_g      <= seen_g_d;
      seen_y      <= seen_y_d;
      fault       <= (state_d == MON_FAULT);
      fault_code  <= code_d;
      cycle_done  <= done_d;
      if (done_d) cycle_count <= cycle_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: per-cycle expectations queued at
// drive time and compared when the two-cycle-delayed outputs appear.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        red = 1'b0, yellow = 1'b0, green = 1'b0;
  logic [1:0]  phase;
  logic        fault;
  logic [2:0]  fault_code;
  logic        cycle_done;
  logic [15:0] cycle_count;

  traffic_light_monitor #(
    .GREEN_CYCLES  (10),
    .YELLOW_CYCLES (5),
    .RED_CYCLES    (30),
    .TOL           (1),
    .CNT_W         (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .phase       (phase),
    .fault       (fault),
    .fault_code  (fault_code),
    .cycle_done  (cycle_done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    int          kind;
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          chk_n = 0;
  int          err_n = 0;

  logic        e_fault;
  logic [2:0]  e_code;
  logic        e_done;
  logic [15:0] e_count;
  string       cur_test;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] exp_phase(input logic r, input logic y, input logic g);
    if ({r, y, g} == 3'b001) return 2'b00;
    if ({r, y, g} == 3'b010) return 2'b01;
    if ({r, y, g} == 3'b100) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [15:0] observe(input int kind);
    case (kind)
      0:       return {14'd0, phase};
      1:       return {15'd0, fault};
      2:       return {13'd0, fault_code};
      3:       return {15'd0, cycle_done};
      default: return cycle_count;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      logic [15:0] obs;
      e = sb.pop_front();
      obs = observe(e.kind);
      chk_n++;
      assert (obs === e.val) else begin
        err_n++;
        $error("FAIL %s observed=%0h expected=%0h cyc=%0d", e.tag, obs, e.val, cyc);
      end
    end
  end

  task automatic push(input int kind, input logic [15:0] val, input string name);
    exp_t e;
    e.due  = cyc + 2;
    e.kind = kind;
    e.val  = val;
    e.tag  = {cur_test, ".", name};
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic y, input logic g, input int n,
                      input bit done_first, input int fault_at, input logic [2:0] code);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      red = r; yellow = y; green = g;
      e_done = 1'b0;
      if (i == 1 && done_first) begin
        e_done  = 1'b1;
        e_count = e_count + 16'd1;
      end
      if (i == fault_at && !e_fault) begin
        e_fault = 1'b1;
        e_code  = code;
      end
      push(0, {14'd0, exp_phase(r, y, g)}, "phase");
      push(1, {15'd0, e_fault}, "fault");
      push(2, {13'd0, e_code}, "fault_code");
      push(3, {15'd0, e_done}, "cycle_done");
      push(4, e_count, "cycle_count");
    end
  endtask

  task automatic direct(input string name, input logic [15:0] obs, input logic [15:0] exp);
    chk_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s.%s observed=%0h expected=%0h", cur_test, name, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    direct("rst_phase", {14'd0, phase}, 16'h3);
    direct("rst_fault", {15'd0, fault}, 16'h0);
    direct("rst_code", {13'd0, fault_code}, 16'h0);
    direct("rst_done", {15'd0, cycle_done}, 16'h0);
    direct("rst_count", cycle_count, 16'h0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk_n++;
    assert (sb.size() == 0) else begin
      err_n++;
      $error("FAIL %s.drain observed=%0d expected=0 pending", cur_test, sb.size());
      sb.delete();
    end
  endtask

  task automatic clear_exp();
    e_fault = 1'b0;
    e_code  = 3'd0;
    e_done  = 1'b0;
    e_count = 16'd0;
  endtask

  task automatic do_reset(input logic r, input logic y, input logic g);
    @(posedge clk);
    #1;
    rst = 1'b1;
    red = r; yellow = y; green = g;
    #1;
    check_reset_values();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_exp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_exp();

    cur_test = "clean";
    do_reset(1'b1, 1'b0, 1'b0);
    step(1, 0, 0, 7,  0, 0, 3'd0);
    step(0, 0, 1, 10, 0, 0, 3'd0);
    step(0, 1, 0, 5,  0, 0, 3'd0);
    step(1, 0, 0, 30, 0, 0, 3'd0);
    step(0, 0, 1, 10, 1, 0, 3'd0);
    step(0, 1, 0, 5,  0, 0, 3'd0);
    step(1, 0, 0, 30, 0, 0, 3'd0);
    cur_test = "short";
    step(0, 0, 1, 9,  1, 0, 3'd0);
    step(0, 1, 0, 5,  0, 0, 3'd0);
    step(1, 0, 0, 30, 0, 0, 3'd0);
    step(0, 0, 1, 8,  1, 0, 3'd0);
    step(0, 1, 0, 5,  0, 1, 3'd3);
    step(1, 0, 0, 5,  0, 0, 3'd0);
    drain();

    cur_test = "long";
    do_reset(1'b1, 1'b0, 1'b0);
    step(1, 0, 0, 5,  0, 0, 3'd0);
    step(0, 0, 1, 10, 0, 0, 3'd0);
    step(0, 1, 0, 5,  0, 0, 3'd0);
    step(1, 0, 0, 33, 0, 32, 3'd4);
    step(0, 0, 1, 5,  0, 0, 3'd0);
    drain();

    cur_test = "illegal";
    do_reset(1'b1, 1'b0, 1'b0);
    step(1, 0, 0, 4,  0, 0, 3'd0);
    step(0, 0, 1, 5,  0, 0, 3'd0);
    step(1, 0, 1, 1,  0, 1, 3'd1);
    step(0, 0, 1, 3,  0, 0, 3'd0);
    step(1, 0, 0, 3,  0, 0, 3'd0);
    drain();

    cur_test = "order";
    do_reset(1'b1, 1'b0, 1'b0);
    step(1, 0, 0, 4,  0, 0, 3'd0);
    step(0, 0, 1, 10, 0, 0, 3'd0);
    step(1, 0, 0, 30, 0, 1, 3'd2);
    step(0, 1, 0, 3,  0, 0, 3'd0);
    drain();

    cur_test = "midrst";
    do_reset(1'b1, 1'b0, 1'b0);
    step(1, 0, 0, 4,  0, 0, 3'd0);
    step(0, 0, 1, 10, 0, 0, 3'd0);
    step(0, 1, 0, 5,  0, 0, 3'd0);
    step(1, 0, 0, 30, 0, 0, 3'd0);
    step(0, 0, 1, 5,  1, 0, 3'd0);
    step(1, 0, 1, 1,  0, 1, 3'd1);
    step(0, 0, 1, 3,  0, 0, 3'd0);
    drain();
    #2;
    rst = 1'b1;
    #1;
    check_reset_values();
    @(posedge clk);
    #1;
    red = 1'b0; yellow = 1'b1; green = 1'b0;
    rst = 1'b0;
    clear_exp();
    step(0, 1, 0, 40, 0, 0, 3'd0);
    step(1, 0, 0, 30, 0, 0, 3'd0);
    step(0, 0, 1, 10, 0, 0, 3'd0);
    step(0, 1, 0, 5,  0, 0, 3'd0);
    step(1, 0, 0, 30, 0, 0, 3'd0);
    step(0, 0, 1, 3,  1, 0, 3'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
    $finish;
  end

endmodule
